ula_multiciclo: RTL

Parametrised multi-cycle ALU for the LabSO processor datapath, replacing the purely combinational ALU stage. Single-cycle operations complete in one clock; multiplication, division and remainder run on an iterative shift-add / restoring-division engine over WIDTH cycles. A start/busy/done handshake lets the control unit stall the pipeline while a long operation is in flight. All outputs are registered and held until the next completed operation.

---
 rtl/ula_multiciclo_pkg.sv | 26 ++
 rtl/ula_multiciclo_if.sv | 25 ++
 rtl/ula_multiciclo_mult_div_seq.sv | 66 ++++++
 rtl/ula_multiciclo.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ula_multiciclo_pkg.sv
// Shared opcode constants, FSM state encoding and sizing helper for the multi-cycle ALU.
package ula_pkg;

  localparam logic [4:0] OP_SOMA      = 5'b00000;
  localparam logic [4:0] OP_SUBTRACAO = 5'b00001;
  localparam logic [4:0] OP_MULT      = 5'b00010;
  localparam logic [4:0] OP_DIV       = 5'b00011;
  localparam logic [4:0] OP_RESTO     = 5'b00100;
  localparam logic [4:0] OP_OR        = 5'b00101;
  localparam logic [4:0] OP_AND       = 5'b00110;
  localparam logic [4:0] OP_NOT       = 5'b00111;
  localparam logic [4:0] OP_XOR       = 5'b01000;
  localparam logic [4:0] OP_NOR       = 5'b01001;
  localparam logic [4:0] OP_NAND      = 5'b01010;
  localparam logic [4:0] OP_XNOR      = 5'b01011;
  localparam logic [4:0] OP_MAIOR     = 5'b01110;
  localparam logic [4:0] OP_SEGUIDOR  = 5'b11111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIM} state_t;

  // One extra bit so the iteration counter can hold WIDTH itself
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/ula_multiciclo_if.sv
// Handshake and data bus between the control unit (master) and the multi-cycle ALU (slave).
interface ula_multiciclo_if #(parameter int WIDTH = 32) ();

  logic             start;
  logic [4:0]       ulaOP;
  logic [WIDTH-1:0] RS;
  logic [WIDTH-1:0] RT;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] saidaULA;
  logic [WIDTH-1:0] saidaHI;
  logic [WIDTH-1:0] saidaLO;
  logic             divZero;

  modport master (
    output start, ulaOP, RS, RT,
    input  busy, done, saidaULA, saidaHI, saidaLO, divZero
  );

  modport slave (
    input  start, ulaOP, RS, RT,
    output busy, done, saidaULA, saidaHI, saidaLO, divZero
  );

endinterface

// File: rtl/ula_multiciclo_mult_div_seq.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per clock over WIDTH cycles.
// result presents the value after the current iteration so the caller can register it on the last one.
module mult_div_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               run,
  input  logic               mode_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] hi, lo, operand_b;
  logic             div_q;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum, shifted;
  logic             fits;
  logic [WIDTH-1:0] diff, hi_next, lo_next;

  // hi holds the partial product / partial remainder; lo the multiplier / quotient being built
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand_b} : '0);
    shifted = {hi, lo[WIDTH-1]};
    fits    = shifted >= {1'b0, operand_b};
    diff    = shifted[WIDTH-1:0] - operand_b;
    if (div_q) begin
      hi_next = fits ? diff : shifted[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], fits};
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

  assign result = {hi_next, lo_next};
  assign last   = (count == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      operand_b <= '0;
      div_q     <= 1'b0;
      count     <= '0;
    end else if (load) begin
      hi        <= '0;
      lo        <= a;
      operand_b <= b;
      div_q     <= mode_div;
      count     <= '0;
    end else if (run) begin
      hi        <= hi_next;
      lo        <= lo_next;
      count     <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU top: handshake FSM, single-cycle ALU and registered outputs.
// Long operations (mul/div/rem) are delegated to mult_div_seq.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clock,
  input logic             reset,
  ula_multiciclo_if.slave bus
);

  state_t state, next_state;

  logic               accept, eng_load, eng_run, eng_last, out_we;
  logic [2*WIDTH-1:0] eng_res;
  logic [WIDTH-1:0]   alu_res, nxt_ula, nxt_hi, nxt_lo;
  logic               nxt_dz;
  logic               is_rem_q, rt_zero_q;
  logic [WIDTH-1:0]   ula_q, hi_q, lo_q;
  logic               dz_q;

  mult_div_seq #(.WIDTH(WIDTH)) engine (
    .clock    (clock),
    .reset    (reset),
    .load     (eng_load),
    .run      (eng_run),
    .mode_div (bus.ulaOP != OP_MULT),
    .a        (bus.RS),
    .b        (bus.RT),
    .last     (eng_last),
    .result   (eng_res)
  );

  always_comb begin
    alu_res = '0;
    case (bus.ulaOP)
      OP_SOMA:      alu_res = bus.RS + bus.RT;
      OP_SUBTRACAO: alu_res = bus.RS - bus.RT;
      OP_OR:        alu_res = bus.RS | bus.RT;
      OP_AND:       alu_res = bus.RS & bus.RT;
      OP_NOT:       alu_res = ~bus.RS;
      OP_XOR:       alu_res = bus.RS ^ bus.RT;
      OP_NOR:       alu_res = ~(bus.RS | bus.RT);
      OP_NAND:      alu_res = ~(bus.RS & bus.RT);
      OP_XNOR:      alu_res = ~(bus.RS ^ bus.RT);
      OP_MAIOR:     alu_res = {{(WIDTH-1){1'b0}}, bus.RS > bus.RT};
      OP_SEGUIDOR:  alu_res = bus.RT;
      default:      alu_res = '0;
    endcase
  end

  // Outputs are written on the edge that enters FIM, so done and results appear together
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    eng_load   = 1'b0;
    eng_run    = 1'b0;
    out_we     = 1'b0;
    nxt_ula    = alu_res;
    nxt_hi     = '0;
    nxt_lo     = '0;
    nxt_dz     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          case (bus.ulaOP)
            OP_MULT: begin
              eng_load   = 1'b1;
              next_state = MUL;
            end
            OP_DIV, OP_RESTO: begin
              eng_load   = 1'b1;
              next_state = DIV;
            end
            default: begin
              out_we     = 1'b1;
              next_state = FIM;
            end
          endcase
        end
      end
      MUL, DIV: begin
        eng_run = 1'b1;
        if (eng_last) begin
          out_we     = 1'b1;
          next_state = FIM;
          nxt_hi     = eng_res[2*WIDTH-1:WIDTH];
          nxt_lo     = eng_res[WIDTH-1:0];
          nxt_ula    = is_rem_q ? eng_res[2*WIDTH-1:WIDTH] : eng_res[WIDTH-1:0];
          nxt_dz     = (state == DIV) && rt_zero_q;
        end
      end
      FIM:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      is_rem_q  <= 1'b0;
      rt_zero_q <= 1'b0;
      ula_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        is_rem_q  <= (bus.ulaOP == OP_RESTO);
        rt_zero_q <= (bus.RT == '0);
      end
      if (out_we) begin
        ula_q <= nxt_ula;
        hi_q  <= nxt_hi;
        lo_q  <= nxt_lo;
        dz_q  <= nxt_dz;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FIM);
  assign bus.saidaULA = ula_q;
  assign bus.saidaHI  = hi_q;
  assign bus.saidaLO  = lo_q;
  assign bus.divZero  = dz_q;

endmodule
